// File: rtl/sound_mixer.sv
// sound_mixer: pans the four GBC channel waveforms to left/right per NR51,
// sums them one channel per cycle, scales by NR50 master volume and emits a
// 20-bit stereo sample pair with a one-cycle valid pulse.
// Optional macro SOUND_MIXER_NR52_MASTER_EN adds the NR52 master enable.
module sound_mixer (
   input  logic        I_CLK,
   input  logic        I_RESET,
   input  logic [15:0] I_IOREG_ADDR,
   inout  logic [7:0]  IO_IOREG_DATA,
   input  logic        I_IOREG_WE_L,
   input  logic        I_IOREG_RE_L,
   input  logic [19:0] I_CH1_WAVEFORM,
   input  logic [19:0] I_CH2_WAVEFORM,
   input  logic [19:0] I_CH3_WAVEFORM,
   input  logic [19:0] I_CH4_WAVEFORM,
   input  logic [3:0]  I_CH_ON,
   input  logic        I_SAMPLE_REQ,
   output logic [19:0] O_LEFT,
   output logic [19:0] O_RIGHT,
   output logic        O_SAMPLE_VALID,
   output logic        O_OVERRUN
);

   typedef enum logic [1:0] {IDLE, ACC, SCALE, OUT} state_t;

   localparam logic [15:0] ADDR_NR50 = 16'hFF24;
   localparam logic [15:0] ADDR_NR51 = 16'hFF25;
   localparam logic [15:0] ADDR_NR52 = 16'hFF26;

   state_t      state_q, state_d;
   logic [7:0]  nr50_q, nr50_d;
   logic [7:0]  nr51_q, nr51_d;
   logic [19:0] wave_q [4];
   logic [19:0] wave_d [4];
   logic [3:0]  on_q, on_d;
   logic [2:0]  vl_q, vl_d;
   logic [2:0]  vr_q, vr_d;
   logic [7:0]  pan_q, pan_d;
   logic [21:0] acc_l_q, acc_l_d;
   logic [21:0] acc_r_q, acc_r_d;
   logic [1:0]  k_q, k_d;
   logic [19:0] res_l_q, res_l_d;
   logic [19:0] res_r_q, res_r_d;
   logic [19:0] left_q, left_d;
   logic [19:0] right_q, right_d;
   logic        valid_q, valid_d;
   logic        ovr_q, ovr_d;
   logic        master_ok;
   logic        rd_en;
   logic [7:0]  rd_data;
   logic [24:0] prod_l, prod_r;
   logic [3:0]  en_l, en_r;

`ifdef SOUND_MIXER_NR52_MASTER_EN
   logic        master_q, master_d;
   logic        mst_q, mst_d;
   assign master_ok = master_q;
`else
   assign master_ok = 1'b1;
`endif

   // Register read decode; the bus is only driven on a decoded read
   always_comb begin
      rd_en   = 1'b0;
      rd_data = '0;
      if (!I_IOREG_RE_L) begin
         case (I_IOREG_ADDR)
            ADDR_NR50: begin rd_en = 1'b1; rd_data = nr50_q; end
            ADDR_NR51: begin rd_en = 1'b1; rd_data = nr51_q; end
`ifdef SOUND_MIXER_NR52_MASTER_EN
            ADDR_NR52: begin rd_en = 1'b1; rd_data = {master_q, 3'b111, I_CH_ON}; end
`endif
            default: ;
         endcase
      end
   end

   assign IO_IOREG_DATA = rd_en ? rd_data : 'z;

   // Register writes; NR50/NR51 are locked while the master enable is off
   always_comb begin
      nr50_d = nr50_q;
      nr51_d = nr51_q;
`ifdef SOUND_MIXER_NR52_MASTER_EN
      master_d = master_q;
`endif
      if (!I_IOREG_WE_L) begin
         case (I_IOREG_ADDR)
            ADDR_NR50: if (master_ok) nr50_d = IO_IOREG_DATA;
            ADDR_NR51: if (master_ok) nr51_d = IO_IOREG_DATA;
`ifdef SOUND_MIXER_NR52_MASTER_EN
            ADDR_NR52: begin
               master_d = IO_IOREG_DATA[7];
               if (!IO_IOREG_DATA[7]) begin
                  nr50_d = '0;
                  nr51_d = '0;
               end
            end
`endif
            default: ;
         endcase
      end
   end

   // Sample sequencer: snapshot, accumulate one channel per cycle, scale, output
   always_comb begin
      state_d = state_q;
      wave_d  = wave_q;
      on_d    = on_q;
      vl_d    = vl_q;
      vr_d    = vr_q;
      pan_d   = pan_q;
      acc_l_d = acc_l_q;
      acc_r_d = acc_r_q;
      k_d     = k_q;
      res_l_d = res_l_q;
      res_r_d = res_r_q;
      left_d  = left_q;
      right_d = right_q;
      valid_d = 1'b0;
      ovr_d   = ovr_q | (I_SAMPLE_REQ && (state_q != IDLE));
      en_l    = pan_q[7:4];
      en_r    = pan_q[3:0];
      prod_l  = 25'(acc_l_q) * 25'({1'b0, vl_q} + 4'd1);
      prod_r  = 25'(acc_r_q) * 25'({1'b0, vr_q} + 4'd1);
`ifdef SOUND_MIXER_NR52_MASTER_EN
      mst_d   = mst_q;
`endif
      case (state_q)
         IDLE: begin
            if (I_SAMPLE_REQ) begin
               wave_d[0] = I_CH1_WAVEFORM;
               wave_d[1] = I_CH2_WAVEFORM;
               wave_d[2] = I_CH3_WAVEFORM;
               wave_d[3] = I_CH4_WAVEFORM;
               on_d      = I_CH_ON;
               vl_d      = nr50_q[6:4];
               vr_d      = nr50_q[2:0];
               pan_d     = nr51_q;
`ifdef SOUND_MIXER_NR52_MASTER_EN
               mst_d     = master_q;
`endif
               acc_l_d   = '0;
               acc_r_d   = '0;
               k_d       = '0;
               state_d   = ACC;
            end
         end
         ACC: begin
            if (on_q[k_q] && en_l[k_q]) acc_l_d = acc_l_q + {2'b00, wave_q[k_q]};
            if (on_q[k_q] && en_r[k_q]) acc_r_d = acc_r_q + {2'b00, wave_q[k_q]};
            k_d = k_q + 2'd1;
            if (k_q == 2'd3) state_d = SCALE;
         end
         SCALE: begin
            res_l_d = 20'(prod_l >> 5);
            res_r_d = 20'(prod_r >> 5);
`ifdef SOUND_MIXER_NR52_MASTER_EN
            if (!mst_q) begin
               res_l_d = '0;
               res_r_d = '0;
            end
`endif
            state_d = OUT;
         end
         OUT: begin
            left_d  = res_l_q;
            right_d = res_r_q;
            valid_d = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // All state updates, synchronous active-high reset
   always_ff @(posedge I_CLK) begin
      if (I_RESET) begin
         state_q <= IDLE;
         nr50_q  <= '0;
         nr51_q  <= '0;
         wave_q  <= '{default: '0};
         on_q    <= '0;
         vl_q    <= '0;
         vr_q    <= '0;
         pan_q   <= '0;
         acc_l_q <= '0;
         acc_r_q <= '0;
         k_q     <= '0;
         res_l_q <= '0;
         res_r_q <= '0;
         left_q  <= '0;
         right_q <= '0;
         valid_q <= 1'b0;
         ovr_q   <= 1'b0;
`ifdef SOUND_MIXER_NR52_MASTER_EN
         master_q <= 1'b0;
         mst_q    <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         nr50_q  <= nr50_d;
         nr51_q  <= nr51_d;
         wave_q  <= wave_d;
         on_q    <= on_d;
         vl_q    <= vl_d;
         vr_q    <= vr_d;
         pan_q   <= pan_d;
         acc_l_q <= acc_l_d;
         acc_r_q <= acc_r_d;
         k_q     <= k_d;
         res_l_q <= res_l_d;
         res_r_q <= res_r_d;
         left_q  <= left_d;
         right_q <= right_d;
         valid_q <= valid_d;
         ovr_q   <= ovr_d;
`ifdef SOUND_MIXER_NR52_MASTER_EN
         master_q <= master_d;
         mst_q    <= mst_d;
`endif
      end
   end

   assign O_LEFT         = left_q;
   assign O_RIGHT        = right_q;
   assign O_SAMPLE_VALID = valid_q;
   assign O_OVERRUN      = ovr_q;

endmodule

// File: tb/tb_sound_mixer.sv
// Testbench for sound_mixer: directed cases plus randomized samples checked
// against an arithmetic reference of the mixing rules.
module tb_sound_mixer;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] addr;
   logic        we_l, re_l;
   logic [19:0] wv [4];
   logic [3:0]  on;
   logic        req;
   wire  [7:0]  io;
   logic [7:0]  drv_data;
   logic        drv_en;
   logic [19:0] o_left, o_right;
   logic        o_valid, o_ovr;

   int          total = 0;
   int          bad   = 0;
   logic [7:0]  m50, m51;
   bit          mm;
   int          lat, pulses;
   logic [19:0] gl, gr, el, er;
   logic [7:0]  rv;

   always #5 clk = ~clk;

   assign io = drv_en ? drv_data : 8'hzz;

   sound_mixer dut (
      .I_CLK          (clk),
      .I_RESET        (rst),
      .I_IOREG_ADDR   (addr),
      .IO_IOREG_DATA  (io),
      .I_IOREG_WE_L   (we_l),
      .I_IOREG_RE_L   (re_l),
      .I_CH1_WAVEFORM (wv[0]),
      .I_CH2_WAVEFORM (wv[1]),
      .I_CH3_WAVEFORM (wv[2]),
      .I_CH4_WAVEFORM (wv[3]),
      .I_CH_ON        (on),
      .I_SAMPLE_REQ   (req),
      .O_LEFT         (o_left),
      .O_RIGHT        (o_right),
      .O_SAMPLE_VALID (o_valid),
      .O_OVERRUN      (o_ovr)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Mixing rule: pan-gated sum, times (vol+1), divided by 32
   function automatic logic [19:0] mix(input bit left, input logic [3:0] onm,
                                       input logic [7:0] n50, input logic [7:0] n51, input bit mst);
      int unsigned sum, vol;
      sum = 0;
      for (int k = 0; k < 4; k++)
         if (onm[k] && (left ? n51[4+k] : n51[k])) sum += 32'(wv[k]);
      vol = left ? 32'(n50[6:4]) : 32'(n50[2:0]);
      if (!mst) return '0;
      return 20'((sum * (vol + 1)) / 32);
   endfunction

   task automatic wr(input logic [15:0] a, input logic [7:0] d);
      addr = a; drv_data = d; drv_en = 1'b1; we_l = 1'b0;
      @(posedge clk); #1;
      we_l = 1'b1; drv_en = 1'b0;
      if (a == 16'hFF24 && mm) m50 = d;
      if (a == 16'hFF25 && mm) m51 = d;
`ifdef SOUND_MIXER_NR52_MASTER_EN
      if (a == 16'hFF26) begin
         mm = d[7];
         if (!d[7]) begin m50 = '0; m51 = '0; end
      end
`endif
   endtask

   task automatic rd(input logic [15:0] a, output logic [7:0] d);
      addr = a; re_l = 1'b0;
      #1 d = io;
      re_l = 1'b1;
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      m50 = '0; m51 = '0;
`ifdef SOUND_MIXER_NR52_MASTER_EN
      mm = 1'b0;
      wr(16'hFF26, 8'h80);
`else
      mm = 1'b1;
`endif
   endtask

   // Request at edge N, then watch edges N+1..N+15; optional second request
   // and optional bus write placed before a chosen edge N+c
   task automatic run_sample(input int req2_at, input int wr_at, input logic [15:0] wa,
                             input logic [7:0] wd, output int lt, output int np,
                             output logic [19:0] l, output logic [19:0] r);
      lt = -1; np = 0; l = 'x; r = 'x;
      req = 1'b1;
      @(posedge clk); #1;
      req = 1'b0;
      for (int c = 1; c <= 15; c++) begin
         req = (c == req2_at);
         if (c == wr_at) wr(wa, wd);
         else begin @(posedge clk); #1; end
         req = 1'b0;
         if (o_valid) begin
            np++;
            if (lt < 0) begin lt = c; l = o_left; r = o_right; end
         end
      end
   endtask

   initial begin
      rst = 1'b1; addr = '0; we_l = 1'b1; re_l = 1'b1; req = 1'b0;
      drv_en = 1'b0; drv_data = '0; on = '0; mm = 1'b1;
      for (int k = 0; k < 4; k++) wv[k] = '0;
      repeat (3) @(posedge clk);
      #1;
      do_reset();

      // reset state
      chk("rst_left", 32'(o_left), 0);
      chk("rst_right", 32'(o_right), 0);
      chk("rst_valid", 32'(o_valid), 0);
      chk("rst_ovr", 32'(o_ovr), 0);
      rd(16'hFF24, rv); chk("rst_nr50", 32'(rv), 0);
      rd(16'hFF25, rv); chk("rst_nr51", 32'(rv), 0);

      // first sample after reset: latency 6, all panned off
      for (int k = 0; k < 4; k++) wv[k] = 20'h12345;
      on = 4'hF;
      run_sample(0, 0, 16'h0, 8'h0, lat, pulses, gl, gr);
      chk("first_lat", 32'(lat), 6);
      chk("first_pulses", 32'(pulses), 1);
      chk("first_left", 32'(gl), 0);
      chk("first_right", 32'(gr), 0);

      // full scale
      wr(16'hFF25, 8'hFF); wr(16'hFF24, 8'h77);
      for (int k = 0; k < 4; k++) wv[k] = 20'h7FFFF;
      run_sample(0, 0, 16'h0, 8'h0, lat, pulses, gl, gr);
      chk("full_left", 32'(gl), 32'h7FFFF);
      chk("full_right", 32'(gr), 32'h7FFFF);

      // pan and volume split
      wr(16'hFF25, 8'h12); wr(16'hFF24, 8'h30);
      wv[0] = 20'h40000; wv[1] = 20'h40000; wv[2] = 20'h7FFFF; wv[3] = 20'h7FFFF;
      on = 4'b0011;
      run_sample(0, 0, 16'h0, 8'h0, lat, pulses, gl, gr);
      chk("pan_left", 32'(gl), 32'h08000);
      chk("pan_right", 32'(gr), 32'h02000);
      chk("pan_ovr", 32'(o_ovr), 0);

      // channel off, plus a dropped request 3 cycles in
      on = 4'b0001;
      run_sample(3, 0, 16'h0, 8'h0, lat, pulses, gl, gr);
      chk("off_left", 32'(gl), 32'h08000);
      chk("off_right", 32'(gr), 0);
      chk("ovr3_pulses", 32'(pulses), 1);
      chk("ovr3_lat", 32'(lat), 6);
      chk("ovr3_flag", 32'(o_ovr), 1);

      // NR51 cleared at N+2 does not affect the sample in flight
      wr(16'hFF25, 8'hFF); wr(16'hFF24, 8'h77);
      for (int k = 0; k < 4; k++) wv[k] = 20'h7FFFF;
      on = 4'hF;
      run_sample(0, 2, 16'hFF25, 8'h00, lat, pulses, gl, gr);
      chk("inflight_left", 32'(gl), 32'h7FFFF);
      chk("inflight_right", 32'(gr), 32'h7FFFF);
      rd(16'hFF25, rv); chk("inflight_nr51", 32'(rv), 0);
      run_sample(0, 0, 16'h0, 8'h0, lat, pulses, gl, gr);
      chk("after_left", 32'(gl), 0);
      chk("after_right", 32'(gr), 0);

      // request at N+6 is an overrun, at N+7 it is accepted
      do_reset();
      run_sample(6, 0, 16'h0, 8'h0, lat, pulses, gl, gr);
      chk("n6_pulses", 32'(pulses), 1);
      chk("n6_ovr", 32'(o_ovr), 1);
      do_reset();
      run_sample(7, 0, 16'h0, 8'h0, lat, pulses, gl, gr);
      chk("n7_pulses", 32'(pulses), 2);
      chk("n7_ovr", 32'(o_ovr), 0);

      // reset mid-sample aborts it without a valid pulse
      req = 1'b1;
      @(posedge clk); #1;
      req = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      pulses = 0;
      for (int c = 0; c < 8; c++) begin
         @(posedge clk); #1;
         if (o_valid) pulses++;
      end
      chk("abort_pulses", 32'(pulses), 0);
      do_reset();

`ifdef SOUND_MIXER_NR52_MASTER_EN
      // master enable off: registers locked and cleared, outputs zero
      wr(16'hFF25, 8'hFF);
      wr(16'hFF26, 8'h00);
      rd(16'hFF25, rv); chk("m_nr51_clr", 32'(rv), 0);
      wr(16'hFF24, 8'h77);
      rd(16'hFF24, rv); chk("m_nr50_lock", 32'(rv), 0);
      for (int k = 0; k < 4; k++) wv[k] = 20'h7FFFF;
      on = 4'hF;
      run_sample(0, 0, 16'h0, 8'h0, lat, pulses, gl, gr);
      chk("m_lat", 32'(lat), 6);
      chk("m_left", 32'(gl), 0);
      chk("m_right", 32'(gr), 0);
      on = 4'b0101;
      wr(16'hFF26, 8'h80);
      rd(16'hFF26, rv); chk("m_nr52", 32'(rv), 32'hF5);
`endif

      // randomized samples against the reference rule
      for (int i = 0; i < 16; i++) begin
         wr(16'hFF24, 8'($urandom));
         wr(16'hFF25, 8'($urandom));
         for (int k = 0; k < 4; k++) wv[k] = 20'($urandom_range(0, 32'h7FFFF));
         on = 4'($urandom);
         el = mix(1'b1, on, m50, m51, mm);
         er = mix(1'b0, on, m50, m51, mm);
         run_sample(0, 0, 16'h0, 8'h0, lat, pulses, gl, gr);
         chk("rand_left", 32'(gl), 32'(el));
         chk("rand_right", 32'(gr), 32'(er));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end

endmodule
